// File: rtl/usr_dac_spi_n.sv
// usr_dac_spi_n: SFR-mapped multi-channel serial DAC transmitter.
// Channels share one SCLK/SIn pair, and each channel has its own active-low SYNC_n.
// Frames are queued per channel through pending bits. Arbitration is fixed
// priority, with the lowest index first.
// With SYNC_ALL set, pending frames wait for a GO before any of them are sent.
//
// Handshake: there is no valid/ready pair on this block. A CPU write is accepted
// on the rising edge where WR_EN & DIRECT_WR & address-hit is true. A read is
// served combinationally in the same cycle that DIRECT_RD is high.
module usr_dac_spi_n #(
  parameter int         NCH       = 4,
  parameter int         DATA_W    = 16,
  parameter logic [7:0] BASE_ADDR = 8'hC0
) (
  input  logic             CPUClock,
  input  logic             RESET,
  input  logic [7:0]       WR_ADDRS,
  input  logic [7:0]       RD_ADDRS,
  input  logic [7:0]       WR_DATA,
  input  logic             WR_EN,
  input  logic             DIRECT_WR,
  input  logic             DIRECT_RD,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output logic             DAC_SCLK,
  output logic             DAC_SIn,
  output logic [NCH-1:0]   DAC_SYNC_n,
  output logic             BUSY,
  output logic [1:0]       dbg_state
);

  localparam int         CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int         BIT_W    = $clog2(DATA_W + 1);
  localparam int         HI_W     = DATA_W - 8;
  localparam logic [7:0] OFF_CTRL = 8'(2 * NCH);
  localparam logic [7:0] OFF_DIV  = 8'(2 * NCH + 1);
  localparam logic [7:0] OFF_STAT = 8'(2 * NCH + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   holding_q [NCH];
  logic [NCH-1:0]      pending_q;
  logic [NCH-1:0]      hi_wr;
  logic [NCH-1:0]      clr_vec;
  logic                en_q, sync_all_q, armed_q;
  logic [7:0]          div_q;
  logic [7:0]          wr_off, rd_off;
  logic                wr_sel, ctrl_wr;
  logic [CH_W-1:0]     win;
  logic                start;
  logic [DATA_W-1:0]   shreg_q;
  logic [CH_W-1:0]     ch_q;
  logic [8:0]          h_q;
  logic [9:0]          cnt_q;
  logic [BIT_W-1:0]    bit_q;
  logic                phase_q;
  logic                h_last, hold_last, last_bit;

  assign wr_off  = WR_ADDRS - BASE_ADDR;
  assign rd_off  = RD_ADDRS - BASE_ADDR;
  assign wr_sel  = WR_EN && DIRECT_WR && (wr_off <= OFF_STAT);
  assign ctrl_wr = wr_sel && (wr_off == OFF_CTRL);

  // High-byte write strobes per channel; each one queues a frame.
  always_comb begin
    hi_wr = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_sel && (wr_off == 8'(2 * c + 1))) hi_wr[c] = 1'b1;
    end
  end

  // Fixed-priority pick: the loop runs downward so the lowest pending index wins.
  always_comb begin
    win = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (pending_q[c]) win = CH_W'(c);
    end
  end

  assign start = (state_q == IDLE) && en_q && (|pending_q) && (!sync_all_q || armed_q);

  // Pending bit of the channel being launched this cycle.
  always_comb begin
    clr_vec = '0;
    if (start) clr_vec[win] = 1'b1;
  end

  // Holding registers; the in-flight frame uses its own shift copy.
  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) begin
      for (int c = 0; c < NCH; c++) holding_q[c] <= '0;
    end else if (wr_sel) begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_off == 8'(2 * c))     holding_q[c][7:0]        <= WR_DATA;
        if (wr_off == 8'(2 * c + 1)) holding_q[c][DATA_W-1:8] <= WR_DATA[HI_W-1:0];
      end
    end
  end

  // Pending set has priority over the launch clear, so a same-cycle rewrite queues again.
  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) pending_q <= '0;
    else       pending_q <= (pending_q & ~clr_vec) | hi_wr;
  end

  // CTRL, DIV and the GO-armed flag.
  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) begin
      en_q       <= 1'b0;
      sync_all_q <= 1'b0;
      armed_q    <= 1'b0;
      div_q      <= '0;
    end else begin
      if (ctrl_wr) begin
        en_q       <= WR_DATA[0];
        sync_all_q <= WR_DATA[1];
      end
      if (wr_sel && (wr_off == OFF_DIV)) div_q <= WR_DATA;
      // GO only arms when the same write keeps SYNC_ALL set.
      if (ctrl_wr && WR_DATA[2] && WR_DATA[1]) armed_q <= 1'b1;
      else if (!en_q || (pending_q == '0))     armed_q <= 1'b0;
    end
  end

  assign h_last    = (cnt_q == ({1'b0, h_q} - 10'd1));
  assign hold_last = (cnt_q == ({h_q, 1'b0} - 10'd1));
  assign last_bit  = (bit_q == BIT_W'(DATA_W - 1));

  // Frame state register.
  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (h_last) state_d = SHIFT;
      SHIFT:   if (h_last && phase_q && last_bit) state_d = HOLD;
      HOLD:    if (hold_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame datapath: the shift register, the half-period counter and the bit counter.
  always_ff @(posedge CPUClock or posedge RESET) begin
    if (RESET) begin
      shreg_q <= '0;
      ch_q    <= '0;
      h_q     <= 9'd1;
      cnt_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q <= holding_q[win];
            ch_q    <= win;
            h_q     <= {1'b0, div_q} + 9'd1;
            cnt_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
          end
        end
        SETUP: cnt_q <= h_last ? '0 : cnt_q + 10'd1;
        SHIFT: begin
          if (h_last) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
            // The next bit appears at the SCLK rise; the frame advances after the high half.
            if (!phase_q) shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
            else          bit_q   <= bit_q + BIT_W'(1);
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        HOLD:    cnt_q <= hold_last ? '0 : cnt_q + 10'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  // Serial outputs decoded from the registered state.
  always_comb begin
    BUSY       = (state_q != IDLE);
    DAC_SCLK   = !((state_q == SHIFT) && !phase_q);
    DAC_SIn    = 1'b0;
    DAC_SYNC_n = '1;
    if ((state_q == SETUP) || (state_q == SHIFT)) begin
      DAC_SIn          = shreg_q[DATA_W-1];
      DAC_SYNC_n[ch_q] = 1'b0;
    end
  end

  assign dbg_state = state_q;

  // Combinational SFR read mux; returns 0 outside the block.
  always_comb begin
    RD_HIT  = DIRECT_RD && (rd_off <= OFF_STAT);
    RD_DATA = '0;
    if (RD_HIT) begin
      for (int c = 0; c < NCH; c++) begin
        if (rd_off == 8'(2 * c))     RD_DATA = holding_q[c][7:0];
        if (rd_off == 8'(2 * c + 1)) RD_DATA = 8'(holding_q[c][DATA_W-1:8]);
      end
      if (rd_off == OFF_CTRL) RD_DATA = {6'b0, sync_all_q, en_q};
      if (rd_off == OFF_DIV)  RD_DATA = div_q;
      if (rd_off == OFF_STAT) RD_DATA = 8'(pending_q) | {BUSY, 7'b0};
    end
  end

endmodule
